// File: rtl/dice_pkg.sv
// Shared types and constants for the dice turn scheduler.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    SETTLE = 2'd2,
    OVER   = 2'd3
  } dice_state_t;

  localparam int FACE_MIN = 1;
  localparam int FACE_MAX = 6;
  localparam int FACE_W   = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int            k;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      idx = IW'(k);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (any) gnt = N'(1) << gnt_idx;
  end

endmodule

// File: rtl/dice_turn_ctrl.sv
// Shares one diceroll between N players: round-robin grant, roll while held,
// capture the settled face into the owner's score and declare a winner.
module dice_turn_ctrl
  import dice_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int TARGET    = 20,
  parameter int SCORE_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PLAYERS-1:0]           req,
  input  logic [FACE_W-1:0]              throw,
  output logic                           dice_button,
  output logic [N_PLAYERS-1:0]           grant,
  output logic [FACE_W-1:0]              result,
  output logic [$clog2(N_PLAYERS)-1:0]   result_player,
  output logic                           result_valid,
  output logic [N_PLAYERS*SCORE_W-1:0]   score,
  output logic                           game_over,
  output logic [$clog2(N_PLAYERS)-1:0]   winner,
  output logic [1:0]                     dbg_state
);

  localparam int IW = $clog2(N_PLAYERS);

  dice_state_t          state_q;
  logic [N_PLAYERS-1:0] grant_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [FACE_W-1:0]    result_q;
  logic [IW-1:0]        result_player_q;
  logic                 result_valid_q;
  logic                 game_over_q;
  logic [IW-1:0]        winner_q;
  logic [SCORE_W-1:0]   score_q [N_PLAYERS];

  logic [N_PLAYERS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [SCORE_W:0]     sum_w;
  logic [SCORE_W-1:0]   score_d;
  logic [IW-1:0]        rr_ptr_d;

  rr_arbiter #(.N(N_PLAYERS), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Extra carry bit lets the add saturate instead of wrapping.
  assign sum_w    = {1'b0, score_q[owner_q]} + (SCORE_W+1)'(throw);
  assign score_d  = sum_w[SCORE_W] ? '1 : sum_w[SCORE_W-1:0];
  assign rr_ptr_d = (owner_q == IW'(N_PLAYERS-1)) ? '0 : owner_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      owner_q         <= '0;
      rr_ptr_q        <= '0;
      result_q        <= '0;
      result_player_q <= '0;
      result_valid_q  <= 1'b0;
      game_over_q     <= 1'b0;
      winner_q        <= '0;
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            owner_q <= arb_idx;
            state_q <= ROLL;
          end
        end
        ROLL: begin
          if (!req[owner_q]) state_q <= SETTLE;
        end
        SETTLE: begin
          result_q           <= throw;
          result_player_q    <= owner_q;
          score_q[owner_q]   <= score_d;
          result_valid_q     <= 1'b1;
          rr_ptr_q           <= rr_ptr_d;
          grant_q            <= '0;
          if (score_d >= SCORE_W'(TARGET)) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
            winner_q    <= owner_q;
          end else begin
            state_q <= IDLE;
          end
        end
        OVER: state_q <= OVER;
        default: state_q <= IDLE;
      endcase
    end
  end

  // result_valid is a one-cycle strobe with no ready: consumers must take it that cycle.
  assign dice_button   = (state_q == ROLL);
  assign grant         = grant_q;
  assign result        = result_q;
  assign result_player = result_player_q;
  assign result_valid  = result_valid_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign dbg_state     = state_q;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
    assign score[g*SCORE_W +: SCORE_W] = score_q[g];
  end

endmodule
